krz_gpio_filter: RTL and testbench

- Parametrised successor to the KRZ GPIO debouncer.
- Synchronises N GPIO inputs and filters each one through a runtime-programmable sample prescaler and a consecutive-stable-sample threshold.
- Emits the debounced levels plus one-cycle rise/fall event pulses per channel.
- Sits between the pad inputs and the KRZ GPIO register block; the register block drives the config and clear ports.

---
 rtl/krz_gpio_filter.sv | 140 ++++++++++++++
 tb/tb_krz_gpio_filter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/krz_gpio_filter.sv
// rtl/krz_gpio_filter.sv - Synchronised, prescaled, threshold-debounced GPIO inputs with edge events
//
// Purpose:
//   Each of N pad inputs passes through a 2-flop synchroniser. A shared
//   programmable prescaler produces sample ticks. On each tick, every channel
//   counts consecutive samples that differ from its debounced level. It accepts
//   the new level once the count reaches the threshold, and then emits a
//   one-cycle rise or fall event.
//
// Ports:
//   clk       system clock
//   rstz      asynchronous active-low reset (all flops clear to 0)
//   gpio_in   raw asynchronous pad inputs [N]
//   div       sample period in clocks minus one [DIV_W]
//   thresh    consecutive differing samples needed to accept a change, 0 acts as 1 [CNT_W]
//   read      debounced levels [N]
//   rise_evt  one-cycle pulse on read 0->1 [N]
//   fall_evt  one-cycle pulse on read 1->0 [N]
//   irq_mask  per-channel interrupt enable [N]
//   irq_clr   write-1-to-clear for irq_pend [N]
//   irq_pend  sticky event-pending bits [N]
//   irq       registered OR of irq_pend & irq_mask
//
// Build option:
//   KRZ_GPIO_FILTER_IRQ_EN - when defined, the pending and irq flops are built.
//   Otherwise irq_pend and irq are tied to 0, and irq_mask and irq_clr are ignored.

module krz_gpio_filter #(
  parameter int N     = 16,
  parameter int DIV_W = 16,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rstz,
  input  logic [N-1:0]     gpio_in,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] thresh,
  output logic [N-1:0]     read,
  output logic [N-1:0]     rise_evt,
  output logic [N-1:0]     fall_evt,
  input  logic [N-1:0]     irq_mask,
  input  logic [N-1:0]     irq_clr,
  output logic [N-1:0]     irq_pend,
  output logic             irq
);

  localparam logic [DIV_W-1:0] PC_ONE  = 1;
  localparam logic [CNT_W:0]   CNT_ONE = 1;

  logic [N-1:0]     sync1;
  logic [N-1:0]     raw;
  logic [DIV_W-1:0] pc;
  logic             tick;
  logic [CNT_W:0]   t_eff;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      sync1 <= '0;
      raw   <= '0;
    end else begin
      sync1 <= gpio_in;
      raw   <= sync1;
    end
  end

  // pc resets to 0, so the first tick lands on the first edge after reset.
  // div is only sampled on reload, so a running period is never cut short.
  assign tick = (pc == '0);

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      pc <= '0;
    end else if (tick) begin
      pc <= div;
    end else begin
      pc <= pc - PC_ONE;
    end
  end

  // The threshold is held one bit wider so that the cnt+1 comparison cannot wrap.
  assign t_eff = (thresh == '0) ? CNT_ONE : {1'b0, thresh};

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;
    logic             read_q;
    logic             rise_q;
    logic             fall_q;

    assign cnt_inc = {1'b0, cnt} + CNT_ONE;

    always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
        cnt    <= '0;
        read_q <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (tick) begin
          if (raw[i] == read_q) begin
            cnt <= '0;
          end else if (cnt_inc >= t_eff) begin
            // This also covers a lowered thresh that is already at or below the count.
            read_q <= raw[i];
            cnt    <= '0;
            rise_q <= raw[i];
            fall_q <= ~raw[i];
          end else begin
            cnt <= cnt_inc[CNT_W-1:0];
          end
        end
      end
    end

    assign read[i]     = read_q;
    assign rise_evt[i] = rise_q;
    assign fall_evt[i] = fall_q;
  end

`ifdef KRZ_GPIO_FILTER_IRQ_EN
  // If an event and a clear arrive together, the event wins.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      irq_pend <= '0;
      irq      <= 1'b0;
    end else begin
      irq_pend <= (irq_pend & ~irq_clr) | rise_evt | fall_evt;
      irq      <= |(irq_pend & irq_mask);
    end
  end
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{irq_mask, irq_clr};
  assign irq_pend = '0;
  assign irq      = 1'b0;
`endif

endmodule

// File: tb/tb_krz_gpio_filter.sv
// tb/tb_krz_gpio_filter.sv - Self-checking bench: vector table, corner sequences, randomized run against a reference model

module tb_krz_gpio_filter;

  logic        clk = 1'b0;
  logic        rstz;
  logic [15:0] gpio_in;
  logic [15:0] div;
  logic [2:0]  thresh;
  logic [15:0] read, rise_evt, fall_evt;
  logic [15:0] irq_mask, irq_clr, irq_pend;
  logic        irq;

  krz_gpio_filter #(.N(16), .DIV_W(16), .CNT_W(3)) dut (
    .clk(clk), .rstz(rstz), .gpio_in(gpio_in), .div(div), .thresh(thresh),
    .read(read), .rise_evt(rise_evt), .fall_evt(fall_evt),
    .irq_mask(irq_mask), .irq_clr(irq_clr), .irq_pend(irq_pend), .irq(irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  bit auto_chk = 1'b0;

  // Reference model. It uses the absolute edge number of the next sample and
  // a run length of differing samples per channel.
  logic [15:0] m_read, m_rise, m_fall, m_pend, h1, h2;
  logic        m_irq;
  int          run [16];
  int          next_tick;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @edge %0d: got %h expected %h", name, edge_n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_read = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_irq = 1'b0;
    h1 = '0; h2 = '0;
    for (int i = 0; i < 16; i++) run[i] = 0;
    next_tick = edge_n + 1;
  endtask

  task automatic model_update();
    logic [15:0] raw, old_evt, old_pend;
    int t;
    if (!rstz) begin
      model_reset();
      return;
    end
    raw = h2;
    old_evt = m_rise | m_fall;
    old_pend = m_pend;
    m_rise = '0;
    m_fall = '0;
    if (edge_n == next_tick) begin
      next_tick = edge_n + int'(div) + 1;
      t = (thresh == 0) ? 1 : int'(thresh);
      for (int i = 0; i < 16; i++) begin
        if (raw[i] == m_read[i]) run[i] = 0;
        else begin
          run[i]++;
          if (run[i] >= t) begin
            m_read[i] = raw[i];
            if (raw[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
            run[i] = 0;
          end
        end
      end
    end
`ifdef KRZ_GPIO_FILTER_IRQ_EN
    m_irq = |(old_pend & irq_mask);
    m_pend = (old_pend & ~irq_clr) | old_evt;
`endif
    h2 = h1;
    h1 = gpio_in;
  endtask

  task automatic check_model();
    chk("read", {16'h0, read}, {16'h0, m_read});
    chk("rise_evt", {16'h0, rise_evt}, {16'h0, m_rise});
    chk("fall_evt", {16'h0, fall_evt}, {16'h0, m_fall});
    chk("irq_pend", {16'h0, irq_pend}, {16'h0, m_pend});
    chk("irq", {31'h0, irq}, {31'h0, m_irq});
  endtask

  // One clock: advance the model at the rising edge and sample at the falling edge.
  task automatic step();
    @(posedge clk);
    edge_n++;
    model_update();
    @(negedge clk);
    if (auto_chk) check_model();
  endtask

  task automatic do_reset();
    rstz = 1'b0;
    #1;
    model_reset();
    step();
    rstz = 1'b1;
  endtask

  // Threshold 4 with div 3: samples at edges 1,5,9,...; an optional one-sample glitch at count 2.
  task automatic run_glitch(input bit glitch, input int exp_edge);
    int base, got, nrise, nfall;
    div = 16'd3; thresh = 3'd4; gpio_in = '0;
    do_reset();
    base = edge_n; got = -1; nrise = 0; nfall = 0;
    gpio_in[2] = 1'b1;
    while (edge_n - base < 60 && got < 0) begin
      step();
      if (glitch && edge_n - base == 7)  gpio_in[2] = 1'b0;
      if (glitch && edge_n - base == 12) gpio_in[2] = 1'b1;
      if (rise_evt[2]) nrise++;
      if (fall_evt[2]) nfall++;
      if (read[2]) got = edge_n - base;
    end
    chk(glitch ? "glitch_rise_edge" : "hold_rise_edge", got, exp_edge);
    chk("thresh4_rise_count", nrise, 1);
    chk("thresh4_fall_count", nfall, 0);
  endtask

  typedef struct {
    logic [15:0] gpio;
    logic [15:0] rd;
    logic [15:0] ri;
    logic [15:0] fa;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int base, got, r;

    tbl[0] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
    tbl[1] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
    tbl[2] = '{16'h0000, 16'h0001, 16'h0001, 16'h0000};
    tbl[3] = '{16'h0000, 16'h0001, 16'h0000, 16'h0000};
    tbl[4] = '{16'h8005, 16'h0000, 16'h0000, 16'h0001};
    tbl[5] = '{16'h8005, 16'h0000, 16'h0000, 16'h0000};
    tbl[6] = '{16'h8004, 16'h8005, 16'h8005, 16'h0000};
    tbl[7] = '{16'h8004, 16'h8005, 16'h0000, 16'h0000};
    tbl[8] = '{16'h8004, 16'h8004, 16'h0000, 16'h0001};

    rstz = 1'b0; gpio_in = '0; div = '0; thresh = 3'd1; irq_mask = '0; irq_clr = '0;
    model_reset();
    step(); step();
    rstz = 1'b1;
    chk("reset_read", {16'h0, read}, 32'h0);
    chk("reset_rise", {16'h0, rise_evt}, 32'h0);
    chk("reset_fall", {16'h0, fall_evt}, 32'h0);
    chk("reset_pend", {16'h0, irq_pend}, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    auto_chk = 1'b1;

    // Vector table with div=0: run once with thresh=1 and once with thresh=0, which must act as 1.
    for (int pass = 0; pass < 2; pass++) begin
      div = '0; thresh = (pass == 0) ? 3'd1 : 3'd0; gpio_in = '0;
      do_reset();
      for (int k = 0; k < 9; k++) begin
        gpio_in = tbl[k].gpio;
        step();
        chk("tbl_read", {16'h0, read}, {16'h0, tbl[k].rd});
        chk("tbl_rise", {16'h0, rise_evt}, {16'h0, tbl[k].ri});
        chk("tbl_fall", {16'h0, fall_evt}, {16'h0, tbl[k].fa});
      end
    end

    run_glitch(1'b0, 17);
    run_glitch(1'b1, 29);

    // div changed from 100 to 2 mid-period: the old 101-cycle period completes, then ticks come every 3 cycles.
    div = 16'd100; thresh = 3'd1; gpio_in = '0;
    do_reset();
    base = edge_n; got = -1;
    gpio_in[1] = 1'b1;
    while (edge_n - base < 150 && got < 0) begin
      step();
      if (edge_n - base == 30) div = 16'd2;
      if (read[1]) got = edge_n - base;
    end
    chk("div_reload_tick", got, 102);
    gpio_in[1] = 1'b0; got = -1;
    while (edge_n - base < 150 && got < 0) begin
      step();
      if (!read[1]) got = edge_n - base;
    end
    chk("div_new_tick1", got, 105);
    gpio_in[1] = 1'b1; got = -1;
    while (edge_n - base < 150 && got < 0) begin
      step();
      if (read[1]) got = edge_n - base;
    end
    chk("div_new_tick2", got, 108);

`ifdef KRZ_GPIO_FILTER_IRQ_EN
    div = '0; thresh = 3'd1; gpio_in = '0; irq_mask = 16'h0020; irq_clr = '0;
    do_reset();
    gpio_in[5] = 1'b1;
    for (int k = 0; k < 20 && !read[5]; k++) step();
    step(); step();
    irq_clr[5] = 1'b1; step(); irq_clr[5] = 1'b0; step(); step();
    gpio_in[5] = 1'b0;
    for (int k = 0; k < 20 && !fall_evt[5]; k++) step();
    chk("irq_fall_seen", {31'h0, fall_evt[5]}, 32'h1);
    step();
    chk("irq_pend_after_fall", {31'h0, irq_pend[5]}, 32'h1);
    step();
    chk("irq_after_fall", {31'h0, irq}, 32'h1);
    gpio_in[5] = 1'b1;
    for (int k = 0; k < 20 && !rise_evt[5]; k++) step();
    irq_clr[5] = 1'b1;
    step();
    chk("irq_set_beats_clr", {31'h0, irq_pend[5]}, 32'h1);
    step();
    irq_clr[5] = 1'b0;
    chk("irq_clr_alone", {31'h0, irq_pend[5]}, 32'h0);
    step();
    chk("irq_low_after_clr", {31'h0, irq}, 32'h0);
`else
    div = '0; thresh = 3'd1; gpio_in = '0; irq_mask = '1; irq_clr = '0;
    do_reset();
    gpio_in = 16'h0020;
    for (int k = 0; k < 6; k++) step();
    chk("noirq_pend", {16'h0, irq_pend}, 32'h0);
    chk("noirq_irq", {31'h0, irq}, 32'h0);
`endif

    // Asynchronous reset in the middle of a count while read=1.
    div = '0; thresh = 3'd4; gpio_in = '0; irq_mask = '1; irq_clr = '0;
    do_reset();
    gpio_in[0] = 1'b1;
    for (int k = 0; k < 20 && !read[0]; k++) step();
    chk("pre_reset_read", {31'h0, read[0]}, 32'h1);
    gpio_in[0] = 1'b0;
    step(); step(); step();
    #2 rstz = 1'b0;
    #1;
    chk("async_reset_read", {16'h0, read}, 32'h0);
    chk("async_reset_evts", {rise_evt, fall_evt}, 32'h0);
    chk("async_reset_irq", {15'h0, irq_pend, irq}, 32'h0);
    model_reset();
    gpio_in[0] = 1'b1;
    step();
    rstz = 1'b1;
    base = edge_n; got = -1; r = 0;
    while (edge_n - base < 20 && got < 0) begin
      step();
      if (fall_evt[0]) r++;
      if (read[0]) got = edge_n - base;
    end
    chk("post_reset_rise_edge", got, 6);
    chk("post_reset_rise_evt", {31'h0, rise_evt[0]}, 32'h1);
    chk("post_reset_no_fall", r, 0);

    // Randomized run against the model.
    div = '0; thresh = 3'd2; gpio_in = '0;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < 16; b++)
        if ($urandom_range(0, 7) == 0) gpio_in[b] = ~gpio_in[b];
      if ($urandom_range(0, 49) == 0) div = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) thresh = 3'($urandom_range(0, 7));
      irq_mask = 16'($urandom);
      irq_clr = 16'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 rstz = 1'b0;
        #1;
        model_reset();
        check_model();
        step();
        rstz = 1'b1;
      end else begin
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
